// File: rtl/l2_ptw_pkg.sv
// Shared widths, PTE bit positions and FSM encoding for the L2 page-table walker.
package l2_ptw_pkg;

    localparam int VPN_W   = 9;
    localparam int PPN_W   = 20;
    localparam int PADDR_W = 32;
    localparam int LEVELS  = 3;
    localparam int VA_W    = VPN_W * LEVELS;
    localparam int PTE_W   = 64;
    localparam int LVL_W   = 2;

    localparam int PTE_V      = 0;
    localparam int PTE_R      = 1;
    localparam int PTE_W_BIT  = 2;
    localparam int PTE_X      = 3;
    localparam int PTE_U      = 4;
    localparam int PTE_G      = 5;
    localparam int PTE_A      = 6;
    localparam int PTE_D      = 7;
    localparam int PTE_PPN_LO = 10;
    localparam int PTE_PPN_HI = 29;

    typedef enum logic [1:0] {
        S_READY = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Level 0 indexes the root table with vpn2, level 2 the last table with vpn0.
    function automatic logic [VPN_W-1:0] vpn_sel(input logic [VA_W-1:0] va,
                                                 input logic [LVL_W-1:0] level);
        case (level)
            2'd0:    vpn_sel = va[3*VPN_W-1:2*VPN_W];
            2'd1:    vpn_sel = va[2*VPN_W-1:VPN_W];
            default: vpn_sel = va[VPN_W-1:0];
        endcase
    endfunction

endpackage

// File: rtl/l2_ptw_pte_check.sv
// Combinational PTE classifier: pointer to next table, leaf, or walk fault.
module l2_ptw_pte_check
    import l2_ptw_pkg::*;
(
    input  logic [PTE_W-1:0] pte,
    input  logic [LVL_W-1:0] level,
    input  logic             store,
    input  logic             err,
    output logic             is_pointer,
    output logic             is_leaf,
    output logic             fault
);

    logic             v, r, w, x, a, d;
    logic [PPN_W-1:0] ppn;
    logic             invalid;
    logic             leaf_bad;
    logic             unused_bits;

    assign unused_bits = ^{pte[PTE_W-1:PTE_PPN_HI+1], pte[PTE_PPN_LO-1:PTE_D+1],
                           pte[PTE_G], pte[PTE_U]};

    always_comb begin
        v   = pte[PTE_V];
        r   = pte[PTE_R];
        w   = pte[PTE_W_BIT];
        x   = pte[PTE_X];
        a   = pte[PTE_A];
        d   = pte[PTE_D];
        ppn = pte[PTE_PPN_HI:PTE_PPN_LO];

        invalid  = !v || (w && !r);
        // Superpage leaves must be naturally aligned to their page size.
        leaf_bad = !a || (store && !d)
                || ((level == 2'd0) && (ppn[17:0] != 18'd0))
                || ((level == 2'd1) && (ppn[8:0] != 9'd0));

        is_pointer = 1'b0;
        is_leaf    = 1'b0;
        fault      = 1'b0;

        if (err || invalid) begin
            fault = 1'b1;
        end else if (!r && !x) begin
            if (level < 2'd2) is_pointer = 1'b1;
            else              fault      = 1'b1;
        end else begin
            is_leaf = 1'b1;
            fault   = leaf_bad;
        end
    end

endmodule

// File: rtl/l2_ptw_walker.sv
// Sv39 page-table walker: one request at a time, up to three PTE reads, one-cycle result pulse.
module l2_ptw_walker
    import l2_ptw_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               io_req_valid,
    output logic               io_req_ready,
    input  logic [VA_W-1:0]    io_req_bits_addr,
    input  logic               io_req_bits_fetch,
    input  logic               io_req_bits_store,
    input  logic               io_req_bits_pum,
    input  logic               io_req_bits_mxr,
    input  logic [1:0]         io_req_bits_prv,
    input  logic [PPN_W-1:0]   io_ptbr_ppn,
    output logic               io_mem_req_valid,
    input  logic               io_mem_req_ready,
    output logic [PADDR_W-1:0] io_mem_req_bits_addr,
    input  logic               io_mem_resp_valid,
    input  logic [PTE_W-1:0]   io_mem_resp_bits_data,
    input  logic               io_mem_resp_bits_err,
    output logic               io_resp_valid,
    output logic [PPN_W-1:0]   io_resp_bits_ppn,
    output logic [7:0]         io_resp_bits_flags,
    output logic [LVL_W-1:0]   io_resp_bits_level,
    output logic               io_resp_bits_fault
);

    state_t           state, state_nxt;
    logic [VA_W-1:0]  r_addr;
    logic             r_store, r_fetch, r_pum, r_mxr;
    logic [1:0]       r_prv;
    logic [PPN_W-1:0] r_ppn;
    logic [LVL_W-1:0] r_level;
    logic [PPN_W-1:0] r_resp_ppn;
    logic [7:0]       r_resp_flags;
    logic [LVL_W-1:0] r_resp_level;
    logic             r_resp_fault;
    logic             is_pointer, is_leaf, pte_fault;
    logic             accept, pte_take;
    logic             unused_attr;

    // Attributes are kept for the TLB's benefit but never steer the walk.
    assign unused_attr = ^{r_fetch, r_pum, r_mxr, r_prv};

    l2_ptw_pte_check u_pte_check (
        .pte        (io_mem_resp_bits_data),
        .level      (r_level),
        .store      (r_store),
        .err        (io_mem_resp_bits_err),
        .is_pointer (is_pointer),
        .is_leaf    (is_leaf),
        .fault      (pte_fault)
    );

    // Handshakes: a transfer happens on a clock edge where valid && ready; the
    // walker holds mem_req valid/addr stable until ready, resp has no back-pressure,
    // and mem responses are only consumed in S_WAIT.
    assign accept   = (state == S_READY) && io_req_valid;
    assign pte_take = (state == S_WAIT) && io_mem_resp_valid;

    always_comb begin
        state_nxt            = state;
        io_req_ready         = 1'b0;
        io_mem_req_valid     = 1'b0;
        io_resp_valid        = 1'b0;
        io_mem_req_bits_addr = {r_ppn, vpn_sel(r_addr, r_level), 3'b000};
        case (state)
            S_READY: begin
                io_req_ready = 1'b1;
                if (io_req_valid) state_nxt = S_REQ;
            end
            S_REQ: begin
                io_mem_req_valid = 1'b1;
                if (io_mem_req_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (io_mem_resp_valid) state_nxt = is_pointer ? S_REQ : S_DONE;
            end
            S_DONE: begin
                io_resp_valid = 1'b1;
                state_nxt     = S_READY;
            end
            default: state_nxt = S_READY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_READY;
            r_addr       <= '0;
            r_store      <= 1'b0;
            r_fetch      <= 1'b0;
            r_pum        <= 1'b0;
            r_mxr        <= 1'b0;
            r_prv        <= '0;
            r_ppn        <= '0;
            r_level      <= '0;
            r_resp_ppn   <= '0;
            r_resp_flags <= '0;
            r_resp_level <= '0;
            r_resp_fault <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                r_addr  <= io_req_bits_addr;
                r_store <= io_req_bits_store;
                r_fetch <= io_req_bits_fetch;
                r_pum   <= io_req_bits_pum;
                r_mxr   <= io_req_bits_mxr;
                r_prv   <= io_req_bits_prv;
                r_ppn   <= io_ptbr_ppn;
                r_level <= '0;
            end
            if (pte_take) begin
                if (is_pointer) begin
                    r_ppn   <= io_mem_resp_bits_data[PTE_PPN_HI:PTE_PPN_LO];
                    r_level <= r_level + 2'd1;
                end else begin
                    // A bus error carries no trustworthy PTE, so report zeros.
                    r_resp_ppn   <= io_mem_resp_bits_err ? '0
                                  : io_mem_resp_bits_data[PTE_PPN_HI:PTE_PPN_LO];
                    r_resp_flags <= io_mem_resp_bits_err ? '0 : io_mem_resp_bits_data[7:0];
                    r_resp_level <= r_level;
                    r_resp_fault <= pte_fault || !is_leaf;
                end
            end
        end
    end

    assign io_resp_bits_ppn   = r_resp_ppn;
    assign io_resp_bits_flags = r_resp_flags;
    assign io_resp_bits_level = r_resp_level;
    assign io_resp_bits_fault = r_resp_fault;

endmodule

// File: tb/tb_l2_ptw_walker.sv
// Directed bench for l2_ptw_walker: memory responder tasks plus hand-computed expected results.
module tb_l2_ptw_walker;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_req_valid;
    logic        io_req_ready;
    logic [26:0] io_req_bits_addr;
    logic        io_req_bits_fetch, io_req_bits_store, io_req_bits_pum, io_req_bits_mxr;
    logic [1:0]  io_req_bits_prv;
    logic [19:0] io_ptbr_ppn;
    logic        io_mem_req_valid;
    logic        io_mem_req_ready;
    logic [31:0] io_mem_req_bits_addr;
    logic        io_mem_resp_valid;
    logic [63:0] io_mem_resp_bits_data;
    logic        io_mem_resp_bits_err;
    logic        io_resp_valid;
    logic [19:0] io_resp_bits_ppn;
    logic [7:0]  io_resp_bits_flags;
    logic [1:0]  io_resp_bits_level;
    logic        io_resp_bits_fault;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int t_acc = 0;

    localparam logic [26:0] VA   = {9'h001, 9'h002, 9'h003};
    localparam logic [19:0] PTBR = 20'h00100;

    l2_ptw_walker dut (
        .clock                 (clock),
        .reset                 (reset),
        .io_req_valid          (io_req_valid),
        .io_req_ready          (io_req_ready),
        .io_req_bits_addr      (io_req_bits_addr),
        .io_req_bits_fetch     (io_req_bits_fetch),
        .io_req_bits_store     (io_req_bits_store),
        .io_req_bits_pum       (io_req_bits_pum),
        .io_req_bits_mxr       (io_req_bits_mxr),
        .io_req_bits_prv       (io_req_bits_prv),
        .io_ptbr_ppn           (io_ptbr_ppn),
        .io_mem_req_valid      (io_mem_req_valid),
        .io_mem_req_ready      (io_mem_req_ready),
        .io_mem_req_bits_addr  (io_mem_req_bits_addr),
        .io_mem_resp_valid     (io_mem_resp_valid),
        .io_mem_resp_bits_data (io_mem_resp_bits_data),
        .io_mem_resp_bits_err  (io_mem_resp_bits_err),
        .io_resp_valid         (io_resp_valid),
        .io_resp_bits_ppn      (io_resp_bits_ppn),
        .io_resp_bits_flags    (io_resp_bits_flags),
        .io_resp_bits_level    (io_resp_bits_level),
        .io_resp_bits_fault    (io_resp_bits_fault)
    );

    // Clock and cycle counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one request at a negedge; the following posedge accepts it (cycle t_acc).
    task automatic send_req(input string tag, input logic store);
        int n = 0;
        while (!io_req_ready && n < 20) begin @(negedge clock); n++; end
        chk({tag, "_req_ready"}, 64'(io_req_ready), 64'd1);
        io_req_valid      = 1'b1;
        io_req_bits_addr  = VA;
        io_req_bits_store = store;
        io_req_bits_fetch = 1'b1;
        io_req_bits_pum   = 1'b1;
        io_req_bits_mxr   = 1'b1;
        io_req_bits_prv   = 2'd3;
        io_ptbr_ppn       = PTBR;
        t_acc             = cyc;
        @(negedge clock);
        io_req_valid = 1'b0;
        io_ptbr_ppn  = 20'hABCDE;
    endtask

    // Answer one PTE read: optional stall cycles (with an optional stray response), then data.
    task automatic serve(input string tag, input logic [31:0] exp_addr, input logic [63:0] data,
                         input logic err, input int stall, input logic stray);
        int n = 0;
        while (!io_mem_req_valid && n < 20) begin @(negedge clock); n++; end
        chk({tag, "_mreq_valid"}, 64'(io_mem_req_valid), 64'd1);
        for (int i = 0; i < stall; i++) begin
            chk({tag, "_stall_addr"}, 64'(io_mem_req_bits_addr), 64'(exp_addr));
            io_mem_resp_valid     = stray && (i == 1);
            io_mem_resp_bits_data = 64'h0000_0000_1000_00CF;
            @(negedge clock);
            io_mem_resp_valid = 1'b0;
        end
        chk({tag, "_mreq_valid_held"}, 64'(io_mem_req_valid), 64'd1);
        chk({tag, "_mreq_addr"}, 64'(io_mem_req_bits_addr), 64'(exp_addr));
        io_mem_req_ready = 1'b1;
        @(negedge clock);
        io_mem_req_ready      = 1'b0;
        io_mem_resp_valid     = 1'b1;
        io_mem_resp_bits_data = data;
        io_mem_resp_bits_err  = err;
        @(negedge clock);
        io_mem_resp_valid    = 1'b0;
        io_mem_resp_bits_err = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int lat, input logic [19:0] ppn,
                             input logic [7:0] flags, input logic [1:0] level, input logic fault);
        int n = 0;
        while (!io_resp_valid && n < 30) begin @(negedge clock); n++; end
        chk({tag, "_resp_valid"}, 64'(io_resp_valid), 64'd1);
        chk({tag, "_latency"}, 64'(cyc - t_acc), 64'(lat));
        chk({tag, "_no_mreq"}, 64'(io_mem_req_valid), 64'd0);
        chk({tag, "_ppn"}, 64'(io_resp_bits_ppn), 64'(ppn));
        chk({tag, "_flags"}, 64'(io_resp_bits_flags), 64'(flags));
        chk({tag, "_level"}, 64'(io_resp_bits_level), 64'(level));
        chk({tag, "_fault"}, 64'(io_resp_bits_fault), 64'(fault));
        @(negedge clock);
        chk({tag, "_resp_pulse"}, 64'(io_resp_valid), 64'd0);
        chk({tag, "_ready_again"}, 64'(io_req_ready), 64'd1);
    endtask

    initial begin
        reset                 = 1'b1;
        io_req_valid          = 1'b0;
        io_req_bits_addr      = '0;
        io_req_bits_fetch     = 1'b0;
        io_req_bits_store     = 1'b0;
        io_req_bits_pum       = 1'b0;
        io_req_bits_mxr       = 1'b0;
        io_req_bits_prv       = '0;
        io_ptbr_ppn           = '0;
        io_mem_req_ready      = 1'b0;
        io_mem_resp_valid     = 1'b0;
        io_mem_resp_bits_data = '0;
        io_mem_resp_bits_err  = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_req_ready", 64'(io_req_ready), 64'd1);
        chk("rst_mreq_valid", 64'(io_mem_req_valid), 64'd0);
        chk("rst_resp_valid", 64'(io_resp_valid), 64'd0);
        chk("rst_resp_bits", 64'({io_resp_bits_ppn, io_resp_bits_flags, io_resp_bits_level,
                                  io_resp_bits_fault}), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // 1: full 3-level walk, ptbr changed after accept
        send_req("walk3", 1'b0);
        serve("walk3_l0", 32'h0010_0008, 64'h80001, 1'b0, 0, 1'b0);
        serve("walk3_l1", 32'h0020_0010, 64'hC0001, 1'b0, 0, 1'b0);
        serve("walk3_l2", 32'h0030_0018, 64'h48D14C7, 1'b0, 0, 1'b0);
        wait_resp("walk3", 7, 20'h12345, 8'hC7, 2'd2, 1'b0);

        // 2: invalid level-0 PTE
        send_req("inv0", 1'b0);
        serve("inv0_l0", 32'h0010_0008, 64'h0, 1'b0, 0, 1'b0);
        wait_resp("inv0", 3, 20'h0, 8'h00, 2'd0, 1'b1);

        // 3: store to a clean page
        send_req("clean", 1'b1);
        serve("clean_l0", 32'h0010_0008, 64'h80001, 1'b0, 0, 1'b0);
        serve("clean_l1", 32'h0020_0010, 64'hC0001, 1'b0, 0, 1'b0);
        serve("clean_l2", 32'h0030_0018, 64'h48D1447, 1'b0, 0, 1'b0);
        wait_resp("clean", 7, 20'h12345, 8'h47, 2'd2, 1'b1);

        // 4: misaligned then aligned 2 MiB superpage
        send_req("mis1", 1'b0);
        serve("mis1_l0", 32'h0010_0008, 64'h80001, 1'b0, 0, 1'b0);
        serve("mis1_l1", 32'h0020_0010, 64'h8044F, 1'b0, 0, 1'b0);
        wait_resp("mis1", 5, 20'h00201, 8'h4F, 2'd1, 1'b1);
        send_req("ali1", 1'b0);
        serve("ali1_l0", 32'h0010_0008, 64'h80001, 1'b0, 0, 1'b0);
        serve("ali1_l1", 32'h0020_0010, 64'h8004F, 1'b0, 0, 1'b0);
        wait_resp("ali1", 5, 20'h00200, 8'h4F, 2'd1, 1'b0);

        // Aligned 1 GiB leaf at level 0
        send_req("giga", 1'b0);
        serve("giga_l0", 32'h0010_0008, 64'h1000_00CF, 1'b0, 0, 1'b0);
        wait_resp("giga", 3, 20'h40000, 8'hCF, 2'd0, 1'b0);

        // Bus error at level 1 zeroes ppn/flags
        send_req("berr", 1'b0);
        serve("berr_l0", 32'h0010_0008, 64'h80001, 1'b0, 0, 1'b0);
        serve("berr_l1", 32'h0020_0010, 64'h48D14C7, 1'b1, 0, 1'b0);
        wait_resp("berr", 5, 20'h0, 8'h00, 2'd1, 1'b1);

        // Pointer found at the last level
        send_req("ptr2", 1'b0);
        serve("ptr2_l0", 32'h0010_0008, 64'h80001, 1'b0, 0, 1'b0);
        serve("ptr2_l1", 32'h0020_0010, 64'hC0001, 1'b0, 0, 1'b0);
        serve("ptr2_l2", 32'h0030_0018, 64'h00001, 1'b0, 0, 1'b0);
        wait_resp("ptr2", 7, 20'h0, 8'h01, 2'd2, 1'b1);

        // 5: back-pressure with a stray response during S_REQ
        send_req("bp", 1'b0);
        serve("bp_l0", 32'h0010_0008, 64'h80001, 1'b0, 5, 1'b1);
        serve("bp_l1", 32'h0020_0010, 64'hC0001, 1'b0, 0, 1'b0);
        serve("bp_l2", 32'h0030_0018, 64'h48D14C7, 1'b0, 0, 1'b0);
        wait_resp("bp", 12, 20'h12345, 8'hC7, 2'd2, 1'b0);

        // 6: reset while in S_WAIT, then a late response
        send_req("rstw", 1'b0);
        chk("rstw_mreq_valid", 64'(io_mem_req_valid), 64'd1);
        io_mem_req_ready = 1'b1;
        @(negedge clock);
        io_mem_req_ready = 1'b0;
        reset            = 1'b1;
        @(negedge clock);
        reset                 = 1'b0;
        io_mem_resp_valid     = 1'b1;
        io_mem_resp_bits_data = 64'h48D14C7;
        chk("rstw_req_ready", 64'(io_req_ready), 64'd1);
        chk("rstw_resp_bits", 64'({io_resp_bits_ppn, io_resp_bits_flags, io_resp_bits_level,
                                   io_resp_bits_fault}), 64'd0);
        @(negedge clock);
        io_mem_resp_valid = 1'b0;
        chk("rstw_ready_after", 64'(io_req_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("rstw_no_resp", 64'(io_resp_valid), 64'd0);
            chk("rstw_no_mreq", 64'(io_mem_req_valid), 64'd0);
            @(negedge clock);
        end

        // Clean walk after the mid-walk reset
        send_req("post", 1'b0);
        serve("post_l0", 32'h0010_0008, 64'h1000_00CF, 1'b0, 0, 1'b0);
        wait_resp("post", 3, 20'h40000, 8'hCF, 2'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/l2_ptw_walker.md
# l2_ptw_walker

Page-table walker that serves PTW requests issued by the L2 TLB. It accepts one translation request at a time and walks a 3-level Sv39 page table, issuing 64-bit PTE reads to the memory port. It returns the leaf PTE with its level, or a fault, as a single-cycle response pulse. It sits between the L2 TLB request port and the data-cache/memory arbiter.

## Interface
Parameters: none; widths are fixed by `l2_ptw_pkg`.

- `clock`  in  1  sole clock
- `reset`  in  1  synchronous, active-high
- `io_req_valid`  in  1  TLB request valid
- `io_req_ready`  out  1  high only in S_READY
- `io_req_bits_addr`  in  27  VPN as {vpn2, vpn1, vpn0}, 9 bits each
- `io_req_bits_fetch`, `io_req_bits_store`, `io_req_bits_pum`, `io_req_bits_mxr`  in  1 each  request attributes
- `io_req_bits_prv`  in  2  privilege
- `io_ptbr_ppn`  in  20  root table PPN, sampled at request accept
- `io_mem_req_valid`  out  1  PTE read valid
- `io_mem_req_ready`  in  1  memory accepts
- `io_mem_req_bits_addr`  out  32  physical PTE address
- `io_mem_resp_valid`  in  1  read data valid
- `io_mem_resp_bits_data`  in  64  PTE
- `io_mem_resp_bits_err`  in  1  bus error
- `io_resp_valid`  out  1  one-cycle result pulse; no back-pressure
- `io_resp_bits_ppn`  out  20  PTE[29:10]
- `io_resp_bits_flags`  out  8  PTE[7:0] = D A G U X W R V
- `io_resp_bits_level`  out  2  0 = 1 GiB leaf, 1 = 2 MiB leaf, 2 = 4 KiB leaf
- `io_resp_bits_fault`  out  1  walk failed

## Operation
- **States:** S_READY, S_REQ, S_WAIT, S_DONE.
- **S_READY:**
  - On `io_req_valid`, latch addr, store, fetch, pum, mxr, prv and `io_ptbr_ppn` into `r_ppn`.
  - Set `r_level` = 0 and go to S_REQ.
- **S_REQ:**
  - `io_mem_req_valid` = 1.
  - `io_mem_req_bits_addr` = {r_ppn, vpn[r_level], 3'b000}, where level 0 uses vpn2, level 1 uses vpn1 and level 2 uses vpn0.
  - On `io_mem_req_ready`, go to S_WAIT.
- **S_WAIT:** On `io_mem_resp_valid`, classify the PTE in `l2_ptw_pte_check`.
  - **Error:** `err` = 1 -> fault.
  - **Invalid:** !V, or W & !R -> fault.
  - **Pointer:** V & !R & !W & !X.
    - If `r_level` < 2: set `r_ppn` = PTE ppn, increment `r_level`, go to S_REQ.
    - If `r_level` == 2: fault.
  - **Leaf:** V & (R | X). It faults if any of the following holds:
    - A = 0;
    - store & D = 0;
    - level 0 with ppn[17:0] != 0;
    - level 1 with ppn[8:0] != 0.
  - Leaf or fault: register ppn, flags, level and fault, then go to S_DONE.
- **S_DONE:** `io_resp_valid` = 1 for exactly one cycle, then S_READY.
- **Fault response:** flags and ppn carry the offending PTE. Level is the level at which the fault occurred. On a bus error, ppn and flags are 0.
- **Unused attributes:** fetch, pum, mxr and prv are latched but do not affect the walk. Permission checks belong to the TLB.

## Timing
- **Reset:**
  - State = S_READY; `r_level`, `r_ppn` and all response registers are 0.
  - `io_req_ready` = 1; `io_mem_req_valid` = 0; `io_resp_valid` = 0; all resp bits are 0.
- **Reset mid-walk:** return to S_READY next cycle. The outstanding memory response is ignored because S_READY disregards `io_mem_resp_valid`.
- **Memory request:** address and valid are held stable until ready.
- **Memory response:**
  - `io_mem_resp_valid` outside S_WAIT is dropped.
  - A response in the same cycle as request acceptance is impossible, because S_REQ does not sample resp.
- **Latency, accept at cycle t, mem ready and 1-cycle response:** each level costs 2 cycles (S_REQ, S_WAIT).
  - Level-0 leaf: resp at t+3.
  - 3-level walk: resp at t+7.
- **Back-to-back requests:** the next request is accepted at the earliest in the cycle after `io_resp_valid`.
- **`io_ptbr_ppn` changes mid-walk:** no effect.

## Structure
- **Package `l2_ptw_pkg`:**
  - state encodings;
  - PTE bit indices (V = 0 … D = 7, PPN at 29:10);
  - widths VPN_W = 9, PPN_W = 20, PADDR_W = 32, LEVELS = 3.
- **Sub-module `l2_ptw_pte_check`:** combinational classifier. It takes pte, level, store and err and outputs is_pointer, is_leaf and fault.
- **Top level:** FSM, address mux, result registers.

## Test plan
Common setup for scenarios 1–3: ptbr = 0x00100, addr = {9'h001, 9'h002, 9'h003}.

1. **3-level walk, mem always ready:**
   - Stimulus: PTEs returned one cycle after each request are 0x80001, then 0xC0001, then 0x48D14C7.
   - Required: mem addresses are 0x00100008, then 0x00200010, then 0x00300018. resp at t+7 with ppn = 0x12345, flags = 0xC7, level = 2, fault = 0.
2. **Invalid PTE at level 0:**
   - Stimulus: level-0 PTE data = 0.
   - Required: single mem read; resp at t+3 with fault = 1, level = 0.
3. **Store to clean page:**
   - Stimulus: store = 1; PTEs as in scenario 1 except the leaf is 0x48D1447 (D = 0).
   - Required: fault = 1, level = 2.
4. **Misaligned superpage:**
   - Stimulus: level-1 leaf with ppn = 0x00201, flags = 0x4F.
   - Required: fault = 1, level = 1. The same leaf with ppn = 0x00200 gives fault = 0.
5. **Back-pressure and stray response:**
   - Stimulus: `io_mem_req_ready` held low 5 cycles; a stray `io_mem_resp_valid` pulse during S_REQ.
   - Required: address is stable and the stray response is ignored. The walk completes 5 cycles later than the ready case.
6. **Reset during S_WAIT:**
   - Stimulus: assert reset, then deliver a late mem response.
   - Required: no `io_resp_valid`; `io_req_ready` = 1 the cycle after reset deasserts.
